// File: rtl/bmtz_block.sv
//------------------------------------------------------------------------------
// Module   : bmtz_block
// Purpose  : 16-line active-low priority encoder driving a seven-segment glyph
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bmtz_block #(
  parameter int unsigned SEG_ACTIVE_LOW = 0
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] DataIn,
  input  logic [7:0] DataIn_0,
  output logic [7:0] Seg
);

  localparam logic [7:0] c_pol  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [6:0] c_dash = 7'h40;

  logic [15:0] r_req;
  logic [15:0] w_act;
  logic [3:0]  w_code;
  logic        w_any;
  logic        w_multi;
  logic [6:0]  w_glyph;
  logic [7:0]  w_seg;

  // Stage 1: capture the raw request vector; reset value means "no line active"
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_req <= 16'hFFFF;
    end else begin
      r_req <= {DataIn, DataIn_0};
    end
  end

  assign w_act   = ~r_req;
  assign w_multi = |(w_act & (w_act - 16'd1));

  // Later iterations overwrite earlier ones, so the highest active index wins
  always_comb begin
    w_code = 4'd0;
    w_any  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (w_act[i]) begin
        w_code = 4'(i);
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_glyph = c_dash;
    if (w_any) begin
      case (w_code)
        4'h0:    w_glyph = 7'h3F;
        4'h1:    w_glyph = 7'h06;
        4'h2:    w_glyph = 7'h5B;
        4'h3:    w_glyph = 7'h4F;
        4'h4:    w_glyph = 7'h66;
        4'h5:    w_glyph = 7'h6D;
        4'h6:    w_glyph = 7'h7D;
        4'h7:    w_glyph = 7'h07;
        4'h8:    w_glyph = 7'h7F;
        4'h9:    w_glyph = 7'h6F;
        4'hA:    w_glyph = 7'h77;
        4'hB:    w_glyph = 7'h7C;
        4'hC:    w_glyph = 7'h39;
        4'hD:    w_glyph = 7'h5E;
        4'hE:    w_glyph = 7'h79;
        default: w_glyph = 7'h71;
      endcase
    end
  end

  assign w_seg = {w_multi, w_glyph} ^ c_pol;

  // Stage 2: output register; blank (all segments off) while in reset
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Seg <= c_pol;
    end else begin
      Seg <= w_seg;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bmtz_block.sv
//------------------------------------------------------------------------------
// Module   : tb_bmtz_block
// Purpose  : directed bench for bmtz_block, both output polarities
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bmtz_block;

  logic        Clk;
  logic        Rst_n;
  logic [15:0] r_vec;
  logic [7:0]  w_seg_hi;
  logic [7:0]  w_seg_lo;

  int n_cmp;
  int n_bad;

  bmtz_block #(.SEG_ACTIVE_LOW(0)) u_dut_hi (
    .Clk(Clk), .Rst_n(Rst_n), .DataIn(r_vec[15:8]), .DataIn_0(r_vec[7:0]), .Seg(w_seg_hi)
  );

  bmtz_block #(.SEG_ACTIVE_LOW(1)) u_dut_lo (
    .Clk(Clk), .Rst_n(Rst_n), .DataIn(r_vec[15:8]), .DataIn_0(r_vec[7:0]), .Seg(w_seg_lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Display expected for a given request vector, straight from the rules
  function automatic logic [7:0] model(input logic [15:0] r);
    logic [6:0] tbl [16];
    int         n_active;
    int         top;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    n_active = 0;
    top = -1;
    for (int i = 15; i >= 0; i--) begin
      if (r[i] == 1'b0) begin
        n_active++;
        if (top < 0) top = i;
      end
    end
    if (top < 0) return 8'h40;
    return {(n_active >= 2) ? 1'b1 : 1'b0, tbl[top]};
  endfunction

  // History of vectors seen at clock edges since reset; Seg reflects the one
  // captured an edge before the current edge
  logic [15:0] hist_q[$];
  logic [7:0]  exp_seg;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hist_q = {};
      exp_seg = 8'h00;
    end else begin
      exp_seg = model((hist_q.size() == 0) ? 16'hFFFF : hist_q[$]);
      hist_q.push_back(r_vec);
      if (hist_q.size() > 4) void'(hist_q.pop_front());
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (Rst_n) begin
      check("cyc_hi", w_seg_hi, exp_seg);
      check("cyc_lo", w_seg_lo, ~exp_seg);
    end else begin
      check("cyc_rst_hi", w_seg_hi, 8'h00);
      check("cyc_rst_lo", w_seg_lo, 8'hFF);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  initial begin
    logic [15:0] v;
    n_cmp = 0;
    n_bad = 0;
    r_vec = 16'hFFFF;
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    #1;
    check("rst_hi", w_seg_hi, 8'h00);
    check("rst_lo", w_seg_lo, 8'hFF);
    tick(2);
    Rst_n = 1'b1;
    tick(2);
    check("idle_dash", w_seg_hi, 8'h40);

    for (int k = 0; k < 16; k++) begin
      v = 16'hFFFF;
      v[k] = 1'b0;
      r_vec = v;
      tick(3);
      if (k == 0)  check("walk0", w_seg_hi, 8'h3F);
      if (k == 10) check("walk10", w_seg_hi, 8'h77);
      if (k == 15) check("walk15", w_seg_hi, 8'h71);
    end

    r_vec = 16'h0000;
    tick(3);
    check("all_active", w_seg_hi, 8'hF1);
    r_vec = 16'hFFFF;
    tick(3);
    check("none_active", w_seg_hi, 8'h40);
    r_vec = 16'hFDF7;
    tick(3);
    check("prio_3_9", w_seg_hi, 8'hEF);
    r_vec = 16'hEFFF & 16'hFFBF;
    tick(3);
    check("prio_12_6", w_seg_hi, 8'hB9);

    r_vec = 16'hFFFE;
    tick(3);
    check("inv_c0", w_seg_lo, 8'hC0);
    r_vec = 16'hFFFD;
    tick(1);
    check("lat_edge1", w_seg_hi, 8'h3F);
    tick(1);
    check("lat_edge2", w_seg_hi, 8'h06);

    r_vec = 16'h7FFF;
    tick(3);
    check("pre_rst", w_seg_hi, 8'h71);
    #1 Rst_n = 1'b0;
    #1;
    check("async_hi", w_seg_hi, 8'h00);
    check("async_lo", w_seg_lo, 8'hFF);
    r_vec = 16'hFFFF;
    tick(2);
    Rst_n = 1'b1;
    tick(1);
    check("post_rst_e1", w_seg_hi, 8'h40);
    tick(1);
    check("post_rst_e2", w_seg_hi, 8'h40);

    r_vec = 16'h5A5A;
    tick(1);
    r_vec = 16'hFFF0;
    tick(1);
    r_vec = 16'hFBFF;
    tick(4);
    check("last", w_seg_hi, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
